// File: rtl/syzygy_dac_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : syzygy_dac_spi_pkg
//  Description : Shared types and constants for the SYZYGY DAC SPI arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package syzygy_dac_spi_pkg;

    localparam int SPI_REG_W              = 6;
    localparam int SPI_DATA_W             = 8;
    localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

    // One transaction in flight: IDLE -> SEND -> WAIT -> DONE -> IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/syzygy_dac_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : syzygy_dac_rr_arbiter
//  Description : Two-way round-robin grant. On a tie the requester that was
//                not granted last wins; the last-grant pointer only moves when
//                a grant is actually taken. Reset favours requester 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module syzygy_dac_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_any,
    output logic       grant_idx
);

    logic r_last;
    logic w_grant_idx;

    // Pick the requester: a tie goes to the one not served last
    always_comb begin
        w_grant_idx = 1'b0;
        if (req == 2'b11) begin
            w_grant_idx = ~r_last;
        end else begin
            w_grant_idx = req[1];
        end
    end

    // Last-grant pointer; reset value 1 makes requester 0 win the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (grant_en && (|req)) begin
            r_last <= w_grant_idx;
        end
    end

    assign grant_any = |req;
    assign grant_idx = w_grant_idx;

endmodule
`default_nettype wire

// File: rtl/syzygy_dac_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : syzygy_dac_spi_arbiter
//  Description : Arbitrates the DAC init controller (0) and the host (1) onto
//                a single SPI register engine, one transaction at a time.
//                Optional WAIT watchdog enabled by macro
//                SYZYGY_DAC_SPI_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module syzygy_dac_spi_arbiter
    import syzygy_dac_spi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int N_REQ          = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*SPI_REG_W-1:0]    req_reg,
    input  logic [N_REQ*SPI_DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]              req_rw,
    output logic [N_REQ-1:0]              req_ack,
    output logic [N_REQ-1:0]              req_done,
    output logic [SPI_DATA_W-1:0]         req_rdata,
    output logic [SPI_REG_W-1:0]          spi_reg,
    output logic [SPI_DATA_W-1:0]         spi_data_in,
    output logic                          spi_rw,
    output logic                          spi_send,
    input  logic                          spi_done,
    input  logic [SPI_DATA_W-1:0]         spi_data_out,
    output logic                          busy,
    output logic                          timeout_err,
    input  logic                          timeout_clr
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_grant;
    logic [SPI_REG_W-1:0]  r_spi_reg;
    logic [SPI_DATA_W-1:0] r_spi_data;
    logic                  r_spi_rw;
    logic [SPI_DATA_W-1:0] r_rdata;
    logic                  w_grant_any;
    logic                  w_grant_idx;
    logic                  w_grant_take;
    logic                  w_timeout;

    syzygy_dac_rr_arbiter u_rr (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .grant_en  (r_state == ST_IDLE),
        .grant_any (w_grant_any),
        .grant_idx (w_grant_idx)
    );

    assign w_grant_take = (r_state == ST_IDLE) && w_grant_any;

`ifdef SYZYGY_DAC_SPI_TIMEOUT_EN
    localparam int                 c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout_err;

    // WAIT-cycle counter, cleared in SEND so it starts at 0 on WAIT entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SEND) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
        end
    end

    // Completion wins over the watchdog when both land in the same cycle
    assign w_timeout = (r_state == ST_WAIT) && !spi_done && (r_wait_cnt == c_cnt_last);

    // Sticky error; a new timeout takes priority over a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (timeout_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    localparam int c_unused_timeout = TIMEOUT_CYCLES;
    logic          w_unused_clr;

    assign w_unused_clr = timeout_clr;
    assign w_timeout    = 1'b0;
    assign timeout_err  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_any) w_state_next = ST_SEND;
            ST_SEND: w_state_next = ST_WAIT;
            ST_WAIT: if (spi_done || w_timeout) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the winner's command on grant; fields hold until the next grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant    <= 1'b0;
            r_spi_reg  <= '0;
            r_spi_data <= '0;
            r_spi_rw   <= 1'b0;
        end else if (w_grant_take) begin
            r_grant <= w_grant_idx;
            if (w_grant_idx) begin
                r_spi_reg  <= req_reg[2*SPI_REG_W-1:SPI_REG_W];
                r_spi_data <= req_data[2*SPI_DATA_W-1:SPI_DATA_W];
                r_spi_rw   <= req_rw[1];
            end else begin
                r_spi_reg  <= req_reg[SPI_REG_W-1:0];
                r_spi_data <= req_data[SPI_DATA_W-1:0];
                r_spi_rw   <= req_rw[0];
            end
        end
    end

    // Read-data capture: engine data on completion (writes too), 0xFF on timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (r_state == ST_WAIT) begin
            if (spi_done) begin
                r_rdata <= spi_data_out;
            end else if (w_timeout) begin
                r_rdata <= 8'hFF;
            end
        end
    end

    assign spi_send    = (r_state == ST_SEND);
    assign req_ack     = {r_grant, ~r_grant} & {N_REQ{r_state == ST_SEND}};
    assign req_done    = {r_grant, ~r_grant} & {N_REQ{r_state == ST_DONE}};
    assign busy        = (r_state != ST_IDLE);
    assign spi_reg     = r_spi_reg;
    assign spi_data_in = r_spi_data;
    assign spi_rw      = r_spi_rw;
    assign req_rdata   = r_rdata;

endmodule
`default_nettype wire
